// File: rtl/up_down_counter_pkg.sv
// -----------------------------------------------------------------------------
// up_down_counter_pkg
//   Shared constants and helpers for the up/down counter.
//   - UDC_DEFAULT_WIDTH : default counter width (8 bits)
//   - UDC_MIN_WIDTH / UDC_MAX_WIDTH : legal width range
//   - udc_dir_e         : direction encoding of up_i
//   - udc_max_count()   : all-ones count value for a given counter width
// -----------------------------------------------------------------------------
package up_down_counter_pkg;

  localparam int unsigned UDC_DEFAULT_WIDTH = 8;
  localparam int unsigned UDC_MIN_WIDTH     = 2;
  localparam int unsigned UDC_MAX_WIDTH     = 32;

  typedef enum logic {
    UDC_DIR_DOWN = 1'b0,
    UDC_DIR_UP   = 1'b1
  } udc_dir_e;

  // Largest value representable in a count of 'width' bits, returned in a
  // 32-bit container so callers can cast it down to their own count width.
  function automatic logic [31:0] udc_max_count(input int unsigned width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

endpackage

// File: rtl/up_down_counter.sv
// -----------------------------------------------------------------------------
// up_down_counter
//   Loadable-on-reset binary up/down counter with terminal-count and
//   registered wrap-around pulse.
//
//   Parameters
//     WIDTH       : counter width, 2..32 (default UDC_DEFAULT_WIDTH = 8)
//     RESET_VALUE : count loaded by reset, must be below 2**WIDTH
//
//   Ports
//     clk_i   in   1      clock, rising edge
//     rst_i   in   1      synchronous active-high reset
//     ce_i    in   1      count enable (0 holds the count)
//     up_i    in   1      direction: 1 = increment, 0 = decrement
//     count_o out  WIDTH  current count, straight from the count register
//     tc_o    out  1      combinational terminal count for the current direction
//     wrap_o  out  1      one-cycle pulse in the cycle after a wrap-around step
//
//   Configuration
//     UP_DOWN_COUNTER_ASSERT_EN : when defined, compiles in embedded
//     assertions (step rule, reset value, wrap pulse) and wrap covers.
//     Functional behaviour is identical either way.
// -----------------------------------------------------------------------------
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = UDC_DEFAULT_WIDTH,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] C_RESET_COUNT = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] C_MAX_COUNT   = WIDTH'(udc_max_count(WIDTH));
  localparam logic [WIDTH-1:0] C_ONE         = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic [WIDTH-1:0] w_count_next;
  logic             w_tc;
  udc_dir_e         w_dir;

  assign w_dir = udc_dir_e'(up_i);

  // Next count and terminal count. The terminal count is the condition under
  // which the next enabled step wraps, so it depends on the live direction.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    w_count_next = r_count;
    w_tc         = 1'b0;
    unique case (w_dir)
      UDC_DIR_UP: begin
        w_count_next = r_count + C_ONE;
        w_tc         = (r_count == C_MAX_COUNT);
      end
      UDC_DIR_DOWN: begin
        w_count_next = r_count - C_ONE;
        w_tc         = (r_count == '0);
      end
      default: begin
        w_count_next = r_count;
        w_tc         = 1'b0;
      end
    endcase
  end

  // Count and wrap registers. Reset wins over enable and direction; a
  // disabled cycle holds the count and clears the wrap pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= C_RESET_COUNT;
      r_wrap  <= 1'b0;
    end else begin
      if (ce_i) begin
        r_count <= w_count_next;
      end
      r_wrap <= w_tc & ce_i;
    end
  end

  assign count_o = r_count;
  assign tc_o    = w_tc;
  assign wrap_o  = r_wrap;

`ifdef UP_DOWN_COUNTER_ASSERT_EN
  // Checks are only meaningful once a reset edge has defined the state, so
  // they are enabled from the edge after the first reset onwards.
  logic r_past_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_past_valid <= 1'b1;
    end
  end

  a_width_legal: assert property (@(posedge clk_i)
    (WIDTH >= UDC_MIN_WIDTH) && (WIDTH <= UDC_MAX_WIDTH));

  a_reset_value: assert property (@(posedge clk_i)
    r_past_valid && $past(rst_i) |-> (count_o == C_RESET_COUNT) && !wrap_o);

  a_step_up: assert property (@(posedge clk_i)
    r_past_valid && !$past(rst_i) && $past(ce_i) && $past(up_i)
      |-> count_o == WIDTH'($past(count_o) + C_ONE));

  a_step_down: assert property (@(posedge clk_i)
    r_past_valid && !$past(rst_i) && $past(ce_i) && !$past(up_i)
      |-> count_o == WIDTH'($past(count_o) - C_ONE));

  a_hold: assert property (@(posedge clk_i)
    r_past_valid && !$past(rst_i) && !$past(ce_i)
      |-> (count_o == $past(count_o)) && !wrap_o);

  a_wrap_pulse: assert property (@(posedge clk_i)
    r_past_valid && !$past(rst_i) |-> wrap_o == $past(tc_o && ce_i));

  c_wrap_up: cover property (@(posedge clk_i)
    r_past_valid && wrap_o && $past(up_i));

  c_wrap_down: cover property (@(posedge clk_i)
    r_past_valid && wrap_o && !$past(up_i));
`endif

endmodule

// File: tb/tb_up_down_counter.sv
// -----------------------------------------------------------------------------
// tb_up_down_counter
//   Directed bench for up_down_counter. Three instances share one clock:
//     u_a : WIDTH=8, RESET_VALUE=0  (main counting, wrap, hold behaviour)
//     u_b : WIDTH=8, RESET_VALUE=5  (reset mid-count and on a wrap edge)
//     u_c : WIDTH=2, RESET_VALUE=0  (back-to-back wraps)
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_up_down_counter;

  logic       clk = 1'b0;

  logic       rst_a, ce_a, up_a;
  logic [7:0] count_a;
  logic       tc_a, wrap_a;

  logic       rst_b, ce_b, up_b;
  logic [7:0] count_b;
  logic       tc_b, wrap_b;

  logic       rst_c, ce_c, up_c;
  logic [1:0] count_c;
  logic       tc_c, wrap_c;

  int n_checks = 0;
  int n_errors = 0;

  always #100 clk = ~clk;

  up_down_counter #(.WIDTH(8), .RESET_VALUE(0)) u_a (
    .clk_i(clk), .rst_i(rst_a), .ce_i(ce_a), .up_i(up_a),
    .count_o(count_a), .tc_o(tc_a), .wrap_o(wrap_a)
  );

  up_down_counter #(.WIDTH(8), .RESET_VALUE(5)) u_b (
    .clk_i(clk), .rst_i(rst_b), .ce_i(ce_b), .up_i(up_b),
    .count_o(count_b), .tc_o(tc_b), .wrap_o(wrap_b)
  );

  up_down_counter #(.WIDTH(2), .RESET_VALUE(0)) u_c (
    .clk_i(clk), .rst_i(rst_c), .ce_i(ce_c), .up_i(up_c),
    .count_o(count_c), .tc_o(tc_c), .wrap_o(wrap_c)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    logic [7:0] down_seq [5];
    logic       down_wrap [5];

    down_seq  = '{8'd2, 8'd1, 8'd0, 8'd255, 8'd254};
    down_wrap = '{1'b0, 1'b0, 1'b0, 1'b1,   1'b0};

    rst_a = 1'b1; ce_a = 1'b0; up_a = 1'b0;
    rst_b = 1'b1; ce_b = 1'b0; up_b = 1'b0;
    rst_c = 1'b1; ce_c = 1'b0; up_c = 1'b0;

    // Reset held for the first 1000 time units (edges at 100..900).
    #901;
    check("reset_count", 32'(count_a), 32'd0);
    check("reset_wrap",  32'(wrap_a),  32'd0);
    @(negedge clk);
    rst_a = 1'b0; ce_a = 1'b1; up_a = 1'b1;

    // First steps after reset: 1, 2, 3, one per clock.
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("up_after_reset_%0d", i), 32'(count_a), 32'(i));
      check($sformatf("up_after_reset_wrap_%0d", i), 32'(wrap_a), 32'd0);
    end

    // Direction change at 3 takes effect on the very next edge; down-wrap.
    up_a = 1'b0;
    #1;
    check("tc_down_at_3", 32'(tc_a), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) check("tc_down_before_zero", 32'(tc_a), 32'd0);
      tick();
      check($sformatf("down_count_%0d", i), 32'(count_a), 32'(down_seq[i]));
      check($sformatf("down_wrap_%0d", i),  32'(wrap_a),  32'(down_wrap[i]));
      if (i == 2) check("tc_down_at_zero", 32'(tc_a), 32'd1);
    end

    // Reset mid-count with enable still high, then 256 up steps.
    rst_a = 1'b1;
    tick();
    check("rerst_count", 32'(count_a), 32'd0);
    check("rerst_wrap",  32'(wrap_a),  32'd0);
    rst_a = 1'b0; up_a = 1'b1; ce_a = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      exp_cnt = i % 256;
      check($sformatf("up256_count_%0d", i), 32'(count_a), 32'(exp_cnt));
      check($sformatf("up256_wrap_%0d", i),  32'(wrap_a),  32'(exp_cnt == 0));
      check($sformatf("up256_tc_%0d", i),    32'(tc_a),    32'(exp_cnt == 255));
    end

    // Disabled at 0 while pointing down: tc high, but no step and no wrap.
    ce_a = 1'b0; up_a = 1'b0;
    #1;
    check("hold0_tc", 32'(tc_a), 32'd1);
    tick();
    check("hold0_count", 32'(count_a), 32'd0);
    check("hold0_wrap",  32'(wrap_a),  32'd0);

    // Count up to 10, then hold for 4 clocks with direction toggling.
    ce_a = 1'b1; up_a = 1'b1;
    repeat (10) tick();
    check("reach10", 32'(count_a), 32'd10);
    ce_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_a = ~up_a;
      tick();
      check($sformatf("hold10_count_%0d", i), 32'(count_a), 32'd10);
      check($sformatf("hold10_wrap_%0d", i),  32'(wrap_a),  32'd0);
    end

    // RESET_VALUE=5 instance: reset value, reset at 200, reset on a wrap edge.
    check("rv5_reset_count", 32'(count_b), 32'd5);
    check("rv5_reset_wrap",  32'(wrap_b),  32'd0);
    rst_b = 1'b0; ce_b = 1'b1; up_b = 1'b1;
    repeat (195) tick();
    check("rv5_reach200", 32'(count_b), 32'd200);
    rst_b = 1'b1;
    tick();
    check("rv5_rst200_count", 32'(count_b), 32'd5);
    check("rv5_rst200_wrap",  32'(wrap_b),  32'd0);
    rst_b = 1'b0;
    tick();
    check("rv5_resume6", 32'(count_b), 32'd6);
    tick();
    check("rv5_resume7", 32'(count_b), 32'd7);
    repeat (248) tick();
    check("rv5_reach255", 32'(count_b), 32'd255);
    check("rv5_tc255",    32'(tc_b),    32'd1);
    ce_b = 1'b0;
    tick();
    check("rv5_hold255_count", 32'(count_b), 32'd255);
    check("rv5_hold255_wrap",  32'(wrap_b),  32'd0);
    ce_b = 1'b1; rst_b = 1'b1;
    tick();
    check("rv5_rstwrap_count", 32'(count_b), 32'd5);
    check("rv5_rstwrap_wrap",  32'(wrap_b),  32'd0);
    rst_b = 1'b0;
    tick();
    check("rv5_after_rstwrap", 32'(count_b), 32'd6);

    // WIDTH=2 instance: continuous up count, a wrap pulse every 4 clocks.
    check("w2_reset_count", 32'(count_c), 32'd0);
    rst_c = 1'b0; ce_c = 1'b1; up_c = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_cnt = i % 4;
      check($sformatf("w2_count_%0d", i), 32'(count_c), 32'(exp_cnt));
      check($sformatf("w2_wrap_%0d", i),  32'(wrap_c),  32'(exp_cnt == 0));
      check($sformatf("w2_tc_%0d", i),    32'(tc_c),    32'(exp_cnt == 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/up_down_counter.md
UP_DOWN_COUNTER -- requirements
Module: up_down_counter

Interface
REQ-001 Parameter WIDTH, default 8, meaning counter bit width; legal range 2..32.
REQ-002 Parameter RESET_VALUE, default 0, meaning count loaded on reset; SHALL be below 2**WIDTH.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 ce_i  input  1  count enable; 0 holds state.
REQ-006 up_i  input  1  direction; 1 increments, 0 decrements.
REQ-007 count_o  output  WIDTH  current count, driven directly from the count register.
REQ-008 tc_o  output  1  combinational terminal count: (up_i and count_o == all ones) or (!up_i and count_o == 0).
REQ-009 wrap_o  output  1  registered one-cycle pulse, high in the cycle after a wrap-around step.

Function
REQ-010 On each rising edge with rst_i=0 and ce_i=1, count SHALL become count+1 if up_i=1, else count-1, modulo 2**WIDTH.
REQ-011 With rst_i=0 and ce_i=0, count and wrap_o SHALL hold count unchanged and drive wrap_o=0 next cycle.
REQ-012 Latency: count_o SHALL reflect a step exactly one clock after the enabling edge; no combinational path from inputs to count_o.
REQ-013 Up-wrap: count all ones, ce_i=1, up_i=1 -> count 0 next cycle, wrap_o=1 for that one cycle.
REQ-014 Down-wrap: count 0, ce_i=1, up_i=0 -> count all ones next cycle, wrap_o=1 for that one cycle.
REQ-015 wrap_o SHALL equal the registered value of (tc_o and ce_i) from the previous edge.
REQ-016 Direction changes SHALL take effect on the same edge where up_i is sampled; no dead cycle.
REQ-017 Consecutive wraps (e.g. WIDTH=2 counting continuously) SHALL produce wrap_o high exactly once per wrap.

Reset
REQ-018 rst_i=1 at a rising edge SHALL load count=RESET_VALUE and wrap_o=0, overriding ce_i and up_i.
REQ-019 Reset asserted mid-count or in a wrap cycle SHALL take precedence; counting resumes from RESET_VALUE on the first edge with rst_i=0 and ce_i=1.
REQ-020 Before the first reset edge, outputs are undefined; no initial values SHALL be relied on.

Configuration
REQ-021 Macro UP_DOWN_COUNTER_ASSERT_EN, when defined, SHALL compile in embedded assertions:
  - the step rule of REQ-010 and REQ-011;
  - the reset value of REQ-018;
  - the wrap_o pulse rule of REQ-015;
  - a cover of both wrap directions.
  All are guarded past the first clock.
REQ-022 Without UP_DOWN_COUNTER_ASSERT_EN, no assertion or cover logic SHALL be present; functional behaviour SHALL be identical either way.

Structure
REQ-023 Package up_down_counter_pkg SHALL hold the default-width constant UDC_DEFAULT_WIDTH=8 and the count type width helper; the module imports it.
REQ-024 No sub-module is natural; single flat module containing the count register, wrap register and terminal-count logic.

Verification
REQ-025 Use WIDTH=8, clock period 200 time units, rst_i=1 for the first 1000 time units, then rst_i=0 with ce_i=1 and up_i=1 -> count_o=0 during reset, then 1,2,3... one per clock.
REQ-026 Count up from 0 for 256 enabled clocks -> count_o 255 then 0, tc_o=1 at 255, wrap_o=1 only in the cycle count_o=0.
REQ-027 Set count 3, up_i=0, ce_i=1 for 5 clocks -> count_o 2,1,0,255,254, wrap_o=1 only when count_o=255.
REQ-028 At count 10, ce_i=0 for 4 clocks with up_i toggling -> count_o stays 10, wrap_o=0.
REQ-029 At count 200 counting up, assert rst_i one cycle with RESET_VALUE=5 -> count_o=5 next cycle, wrap_o=0, then 6,7...
REQ-030 WIDTH=2 continuous up count -> sequence 0,1,2,3,0,1, wrap_o pulsing once every 4 clocks.
